// File: rtl/hypercpu_pkg.sv
// Shared HyperCPU definitions: datapath width, ALU opcode encodings and the
// set of opcodes the issue logic refuses to send to the ALU.
package hypercpu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    OP_NOT = 4'h0,
    OP_AND = 4'h1,
    OP_OR  = 4'h2,
    OP_XOR = 4'h3,
    OP_LT  = 4'h4,
    OP_GT  = 4'h5,
    OP_EQ  = 4'h6,
    OP_NE  = 4'h7,
    OP_SHL = 4'h8,
    OP_SHR = 4'h9,
    OP_ADD = 4'hC,
    OP_SUB = 4'hD,
    OP_MUL = 4'hE,
    OP_DIV = 4'hF
  } alu_op_t;

  // Encodings 0xA and 0xB are unassigned and are rejected at issue time.
  localparam int N_ILLEGAL_OPS = 2;
  localparam logic [3:0] ILLEGAL_OPS [N_ILLEGAL_OPS] = '{4'hA, 4'hB};

  function automatic logic is_illegal_op(input logic [3:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_ILLEGAL_OPS; i++) begin
      if (op == ILLEGAL_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/hypercpu_alu.sv
// Combinational HyperCPU ALU. Comparisons are unsigned and return a
// zero-extended single bit; multiply keeps the low XLEN bits; divide by zero
// returns all ones.
module hypercpu_alu
  import hypercpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] r
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  // Result select by opcode; unassigned encodings produce zero.
  always_comb begin
    r = '0;
    case (alu_op_t'(op))
      OP_NOT: r = ~a;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_LT:  r = {{(XLEN-1){1'b0}}, (a < b)};
      OP_GT:  r = {{(XLEN-1){1'b0}}, (a > b)};
      OP_EQ:  r = {{(XLEN-1){1'b0}}, (a == b)};
      OP_NE:  r = {{(XLEN-1){1'b0}}, (a != b)};
      OP_SHL: r = a << shamt;
      OP_SHR: r = a >> shamt;
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_MUL: r = a * b;
      OP_DIV: r = (b == '0) ? '1 : (a / b);
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/hypercpu_regfile.sv
// Architectural register file: two combinational operand read ports, one
// debug read port and one synchronous write port. r0 is hardwired to zero.
module hypercpu_regfile
  import hypercpu_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = 16,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RW-1:0]   ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [RW-1:0]   rb_addr,
  output logic [XLEN-1:0] rb_data,
  input  logic [RW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  input  logic            we,
  input  logic [RW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs [NREGS];

  // Clear every entry on reset; otherwise commit the write unless it targets r0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports force zero for r0 so the hardwired value never depends on storage.
  always_comb begin
    ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
    rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end

endmodule

// File: rtl/hypercpu_alu_issue.sv
// ALU issue stage: accepts one command at a time, registers operands into an
// external ALU, writes the result back one cycle later and pulses retire.
module hypercpu_alu_issue
  import hypercpu_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = 16,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [RW-1:0]   cmd_rd,
  input  logic [RW-1:0]   cmd_ra,
  input  logic [RW-1:0]   cmd_rb,
  input  logic            cmd_imm_en,
  input  logic [XLEN-1:0] cmd_imm,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_r,
  output logic            ret_valid,
  output logic [RW-1:0]   ret_rd,
  output logic [XLEN-1:0] ret_data,
  output logic            ret_err,
  input  logic [RW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            cmd_fire;
  logic            op_legal;
  logic            wb_en;
  logic [RW-1:0]   rd_q;
  logic [XLEN-1:0] rf_ra_data;
  logic [XLEN-1:0] rf_rb_data;

  // Writeback happens on the edge that ends EXEC, so a command accepted in
  // the retire cycle already reads the freshly written value.
  hypercpu_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (cmd_ra),
    .ra_data  (rf_ra_data),
    .rb_addr  (cmd_rb),
    .rb_data  (rf_rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_en),
    .wr_addr  (rd_q),
    .wr_data  (alu_r)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake: only legal accepted commands enter EXEC.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    cmd_fire   = 1'b0;
    wb_en      = 1'b0;
    op_legal   = !is_illegal_op(cmd_op);
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        cmd_fire  = cmd_valid;
        if (cmd_valid && op_legal) state_next = EXEC;
      end
      EXEC: begin
        wb_en      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latching, retire and error pulses; ALU inputs hold while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rd_q      <= '0;
      ret_valid <= 1'b0;
      ret_rd    <= '0;
      ret_data  <= '0;
      ret_err   <= 1'b0;
    end else begin
      ret_valid <= 1'b0;
      ret_err   <= 1'b0;
      if (cmd_fire && op_legal) begin
        alu_a  <= rf_ra_data;
        alu_b  <= cmd_imm_en ? cmd_imm : rf_rb_data;
        alu_op <= cmd_op;
        rd_q   <= cmd_rd;
      end
      if (cmd_fire && !op_legal) begin
        ret_err <= 1'b1;
      end
      if (wb_en) begin
        ret_valid <= 1'b1;
        ret_rd    <= rd_q;
        ret_data  <= alu_r;
      end
    end
  end

endmodule
